// File: rtl/wb_arb_pkg.sv
// Shared types and default parameters for the writeback port arbiter.
//   arb_state_t : arbiter FSM states (NORMAL, FORCE)
//   wb_entry_t  : one buffered long-latency result (valid, rd, data)
package wb_arb_pkg;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int BUF_DEPTH_DEF    = 2;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// Two-entry buffer for long-latency (mul/div) results awaiting the
// register-file write port.
//   clk, rst        : clock, synchronous active-high reset (clears valid bits)
//   push, push_rd,
//   push_data       : append an entry at the tail
//   pop             : the head entry was written this cycle
//   inv_en, inv_rd  : drop every stored entry whose rd equals inv_rd
//   head_valid,
//   head_rd,
//   head_data       : oldest live entry
//   count           : number of valid entries (registered)
// Entries are compacted every cycle, so slot 0 is always the head and a
// dropped head never occupies a port cycle.
module wb_lu_fifo
  import wb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        inv_en,
  input  logic [4:0]  inv_rd,
  output logic        head_valid,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data,
  output logic [1:0]  count
);

  wb_entry_t  entry_reg  [2];
  wb_entry_t  entry_next [2];
  logic [1:0] keep;

  // An entry survives unless it is invalidated by a younger pipeline write
  // or, for the head slot, written to the register file this cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_keep
      localparam bit IS_HEAD = (gi == 0);
      assign keep[gi] = entry_reg[gi].valid
                      && !(inv_en && (entry_reg[gi].rd == inv_rd))
                      && !(pop && IS_HEAD);
    end
  endgenerate

  always_comb begin
    entry_next[0] = '0;
    entry_next[1] = '0;
    // Compact survivors towards slot 0 preserving order.
    if (keep[0]) begin
      entry_next[0] = entry_reg[0];
      if (keep[1]) begin
        entry_next[1] = entry_reg[1];
      end
    end else if (keep[1]) begin
      entry_next[0] = entry_reg[1];
    end
    // Push lands in the first free slot after compaction; the caller only
    // pushes when fewer than two entries were held, so a slot is free.
    if (push) begin
      if (!entry_next[0].valid) begin
        entry_next[0] = '{valid: 1'b1, rd: push_rd, data: push_data};
      end else begin
        entry_next[1] = '{valid: 1'b1, rd: push_rd, data: push_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        entry_reg[i] <= entry_next[i];
      end
    end
  end

  assign head_valid = entry_reg[0].valid;
  assign head_rd    = entry_reg[0].rd;
  assign head_data  = entry_reg[0].data;
  assign count      = {1'b0, entry_reg[0].valid} + {1'b0, entry_reg[1].valid};

endmodule

// File: rtl/writeback_port_arbiter.sv
// Shares the single register-file write port between the pipeline
// writeback stage and a long-latency unit (mul/div).
//   clk, rst               : clock, synchronous active-high reset
//   RegWriteW, RdW, ResultW: pipeline writeback request
//   lu_valid, lu_rd,
//   lu_data, lu_ready      : long-latency result handshake
//   rf_we, rf_rd, rf_wd    : register-file write port (combinational)
//   stall_req              : freezes the pipeline during a forced drain
// The pipeline normally wins the port; a buffered result denied for
// STARVE_LIMIT consecutive cycles gets one FORCE cycle that stalls the
// pipeline and drains the buffer head.
module writeback_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int BUF_DEPTH    = BUF_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        stall_req
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  arb_state_t  state_reg, state_next;
  logic [2:0]  starve_cnt_reg, starve_cnt_next;

  logic        head_valid;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic [1:0]  count;

  logic        pipe_req;
  logic        pipe_grant;
  logic        head_grant;
  logic        lu_push;

  assign pipe_req = RegWriteW && (RdW != 5'd0);

  always_comb begin
    pipe_grant      = 1'b0;
    head_grant      = 1'b0;
    state_next      = state_reg;
    starve_cnt_next = 3'd0;
    case (state_reg)
      NORMAL: begin
        pipe_grant = pipe_req;
        head_grant = !pipe_req && head_valid;
        // A head that loses to a pipeline write to its own rd is dropped,
        // not starved, so it neither counts nor arms FORCE.
        if (head_valid && pipe_req && (head_rd != RdW)) begin
          starve_cnt_next = (starve_cnt_reg == 3'd7) ? 3'd7 : starve_cnt_reg + 3'd1;
          if (starve_cnt_next >= LIMIT) begin
            state_next = FORCE;
          end
        end
      end
      FORCE: begin
        head_grant = head_valid;
        state_next = NORMAL;
      end
      default: begin
        state_next = NORMAL;
      end
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_rd = 5'd0;
    rf_wd = 32'd0;
    if (!rst) begin
      if (pipe_grant) begin
        rf_we = 1'b1;
        rf_rd = RdW;
        rf_wd = ResultW;
      end else if (head_grant && (head_rd != 5'd0)) begin
        rf_we = 1'b1;
        rf_rd = head_rd;
        rf_wd = head_data;
      end
    end
  end

  // Occupancy is the registered count, so a same-cycle pop does not
  // open the buffer.
  assign lu_ready = !rst && (count < DEPTH);

  // x0 results and results overtaken by a same-cycle pipeline write to the
  // same rd complete the handshake but are never stored.
  assign lu_push = lu_valid && lu_ready && (lu_rd != 5'd0)
                 && !(pipe_grant && (lu_rd == RdW));

  assign stall_req = !rst && (state_reg == FORCE);

  wb_lu_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (lu_push),
    .push_rd    (lu_rd),
    .push_data  (lu_data),
    .pop        (head_grant),
    .inv_en     (pipe_grant),
    .inv_rd     (RdW),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= NORMAL;
      starve_cnt_reg <= 3'd0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule
